// File: rtl/mem_bus_arb.sv
// Round-robin arbiter granting the memory bus to one of 2*NPORTS requesters
// (instruction/data pair per controller port); rid follows the grant by one cycle.

package iu_clk_pkg;
    typedef struct packed {
        logic clk;
    } iu_clk_type;
endpackage

module mem_bus_arb
    import iu_clk_pkg::*;
#(
    parameter int NPORTS = 2,
    localparam int NREQ  = 2 * NPORTS,
    localparam int RW    = ($clog2(NREQ) < 1) ? 1 : $clog2(NREQ)
) (
    input  iu_clk_type        gclk,
    input  logic              rst,
    input  logic              en,
    input  logic [NREQ-1:0]   port_valid,
    output logic [NREQ-1:0]   port_mask,
    output logic [RW-1:0]     rid
);

    logic [RW-1:0]   last_r;
    logic [RW-1:0]   rid_r;
    logic [NREQ-1:0] mask_s;
    logic [RW-1:0]   sel_s;
    logic            found_s;

    // Scan requesters starting just after the last grant; last itself comes last.
    always_comb begin
        mask_s  = {NREQ{1'b0}};
        sel_s   = {RW{1'b0}};
        found_s = 1'b0;
        if (en && !rst && (|port_valid)) begin
            for (int i = 1; i <= NREQ; i++) begin
                if (!found_s && port_valid[(int'(last_r) + i) % NREQ]) begin
                    found_s = 1'b1;
                    sel_s   = RW'((int'(last_r) + i) % NREQ);
                    mask_s[(int'(last_r) + i) % NREQ] = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            mask_s = {NREQ{1'b0}};
        end
    end

    // Pointer and delayed requester ID; reset parks last on the top index so 0 wins next.
    always_ff @(posedge gclk.clk) begin
        if (rst) begin
            last_r <= RW'(NREQ - 1);
            rid_r  <= {RW{1'b0}};
        end else if (found_s) begin
            last_r <= sel_s;
            rid_r  <= sel_s;
        end else begin
            last_r <= last_r;
            rid_r  <= rid_r;
        end
    end

    assign port_mask = mask_s;
    assign rid       = rid_r;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed bench for mem_bus_arb with NPORTS=2 (four requesters).

module tb_mem_bus_arb;
    import iu_clk_pkg::*;

    iu_clk_type  gclk;
    logic        rst;
    logic        en;
    logic [3:0]  port_valid;
    logic [3:0]  port_mask;
    logic [1:0]  rid;

    int n_checks;
    int n_fail;

    mem_bus_arb #(.NPORTS(2)) dut (
        .gclk       (gclk),
        .rst        (rst),
        .en         (en),
        .port_valid (port_valid),
        .port_mask  (port_mask),
        .rid        (rid)
    );

    initial gclk.clk = 1'b0;
    always #5 gclk.clk = ~gclk.clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One cycle: apply inputs on the falling edge, check the grant, then rid after the rising edge.
    task automatic step(input string tag, input logic r, input logic e, input logic [3:0] v,
                        input logic [3:0] exp_mask, input logic [1:0] exp_rid);
        @(negedge gclk.clk);
        rst        = r;
        en         = e;
        port_valid = v;
        #1;
        check({tag, "_mask"}, {4'b0000, port_mask}, {4'b0000, exp_mask});
        @(posedge gclk.clk);
        #1;
        check({tag, "_rid"}, {6'b000000, rid}, {6'b000000, exp_rid});
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        en         = 1'b1;
        port_valid = 4'b1111;

        // Reset holds the grant off
        step("rst0", 1'b1, 1'b1, 4'b1111, 4'b0000, 2'd0);
        step("rst1", 1'b1, 1'b1, 4'b1111, 4'b0000, 2'd0);

        // All valid: strict rotation starting at 0
        step("all0", 1'b0, 1'b1, 4'b1111, 4'b0001, 2'd0);
        step("all1", 1'b0, 1'b1, 4'b1111, 4'b0010, 2'd1);
        step("all2", 1'b0, 1'b1, 4'b1111, 4'b0100, 2'd2);
        step("all3", 1'b0, 1'b1, 4'b1111, 4'b1000, 2'd3);
        step("all4", 1'b0, 1'b1, 4'b1111, 4'b0001, 2'd0);

        // Sparse: last=0, so 2 then 0 alternate
        step("sp0", 1'b0, 1'b1, 4'b0101, 4'b0100, 2'd2);
        step("sp1", 1'b0, 1'b1, 4'b0101, 4'b0001, 2'd0);
        step("sp2", 1'b0, 1'b1, 4'b0101, 4'b0100, 2'd2);
        step("sp3", 1'b0, 1'b1, 4'b0101, 4'b0001, 2'd0);

        // Enable hold after a grant to requester 1
        step("eh0", 1'b0, 1'b1, 4'b1111, 4'b0010, 2'd1);
        step("eh1", 1'b0, 1'b0, 4'b1111, 4'b0000, 2'd1);
        step("eh2", 1'b0, 1'b0, 4'b1111, 4'b0000, 2'd1);
        step("eh3", 1'b0, 1'b0, 4'b1111, 4'b0000, 2'd1);
        step("eh4", 1'b0, 1'b1, 4'b1111, 4'b0100, 2'd2);

        // Single requester granted back to back
        step("one0", 1'b0, 1'b1, 4'b1000, 4'b1000, 2'd3);
        step("one1", 1'b0, 1'b1, 4'b1000, 4'b1000, 2'd3);
        step("one2", 1'b0, 1'b1, 4'b1000, 4'b1000, 2'd3);

        // Nothing valid: no grant, rid holds
        step("idle", 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd3);

        // Mid-run reset restarts the order at 0
        step("mr0", 1'b0, 1'b1, 4'b1111, 4'b0001, 2'd0);
        step("mr1", 1'b0, 1'b1, 4'b1111, 4'b0010, 2'd1);
        step("mr2", 1'b1, 1'b1, 4'b1111, 4'b0000, 2'd0);
        step("mr3", 1'b0, 1'b1, 4'b1111, 4'b0001, 2'd0);
        step("mr4", 1'b0, 1'b1, 4'b1111, 4'b0010, 2'd1);

        // Priority after last=1 skips to the next valid, wrapping past the top
        step("wr0", 1'b0, 1'b1, 4'b0011, 4'b0001, 2'd0);
        step("wr1", 1'b0, 1'b1, 4'b0011, 4'b0010, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arb.md
MEM_BUS_ARB -- requirements
Module: mem_bus_arb

Interface
REQ-001 SHALL have parameter NPORTS, default 2, meaning the number of memory-controller ports; the block serves 2*NPORTS requesters.
REQ-002 SHALL have derived width RW = max(1, ceil(log2(2*NPORTS))), meaning the width of the requester ID.
REQ-003 SHALL have port gclk, input, iu_clk_type: the single clock; only the rising edge of gclk.clk is used.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: memory bus enable (address, write and return buffers can accept a transfer).
REQ-006 SHALL have port port_valid, input, 2*NPORTS bits: requester i has a pending request.
- Even index 2k is the instruction port of controller port k.
- Odd index 2k+1 is the data port of controller port k.
REQ-007 SHALL have port port_mask, output, 2*NPORTS bits: one-hot grant for the current cycle.
REQ-008 SHALL have port rid, output, RW bits: index of the requester granted in the previous cycle.
- rid[0]: 0 = instruction, 1 = data.
- rid[RW-1:1]: controller port number.

Function
REQ-009 SHALL hold internal pointer last (RW bits): the index of the most recently granted requester.
REQ-010 SHALL compute port_mask combinationally in the same cycle as its inputs:
- all zeros when en=0, when rst=1, or when port_valid has no bits set;
- otherwise exactly one bit set, at the first index j with port_valid[j]=1.
REQ-011 SHALL scan for that index in order last+1, last+2, ..., wrapping from 2*NPORTS-1 to 0, with last itself scanned last.
REQ-012 SHALL, on each rising edge where rst=0 and port_mask is non-zero, load last and rid with the index of the set bit in port_mask.
REQ-013 SHALL hold last and rid unchanged on any edge where port_mask is zero.
REQ-014 SHALL give rid a latency of exactly one cycle after port_mask, so it aligns with the registered data-path mux select downstream.
REQ-015 SHALL keep port_mask one-hot or zero at all times; two or more bits set is a design error.
REQ-016 SHALL, when only one requester is valid, grant that requester on every enabled cycle, back to back.
REQ-017 SHALL grant each of K continuously valid requesters exactly once in any K consecutive enabled cycles (round-robin fairness).
REQ-018 SHALL, when port_valid changes in the same cycle, use the new value for that cycle's grant (no registered request sampling).
REQ-019 SHALL support NPORTS=1 (2 requesters, RW=1): rid[0] alone identifies instruction or data.
REQ-020 SHALL gate read-enable only through the caller: the caller forms re[i] = port_valid[i] & port_mask[i] & en.

Reset
REQ-021 SHALL, on a rising edge with rst=1, set last = 2*NPORTS-1 and rid = 0, so requester 0 has highest priority after reset.
REQ-022 SHALL force port_mask = 0 combinationally while rst=1.
REQ-023 SHALL, when rst is asserted mid-operation, discard any grant in progress; the first grant after rst falls follows REQ-021 priority.

Verification (NPORTS=2, 4 requesters)
REQ-024 SHALL pass the reset check:
- rst=1 with port_valid=1111 and en=1 -> port_mask=0000;
- after rst falls -> first grant is 0001, next cycle rid=0.
REQ-025 SHALL pass the all-valid check: port_valid=1111, en=1 -> port_mask sequence 0001, 0010, 0100, 1000, 0001; rid sequence lags one cycle: 0, 1, 2, 3.
REQ-026 SHALL pass the sparse check: port_valid=0101, en=1 -> port_mask alternates 0001, 0100; rid alternates 0, 2.
REQ-027 SHALL pass the enable-hold check:
- after a grant to 0010, en=0 for 3 cycles -> port_mask=0000 and rid holds 1;
- en=1 with port_valid=1111 -> next grant is 0100.
REQ-028 SHALL pass the single-requester check: port_valid=1000, en=1 -> port_mask=1000 every cycle and rid=3 from the second cycle.
REQ-029 SHALL pass the mid-run reset check: rst pulsed for one cycle during the all-valid sequence -> port_mask=0000 in the reset cycle, then grant order restarts at 0001.
